// File: rtl/noise_shaper_mc.sv
// noise_shaper_mc
//   Multichannel requantiser: reduces IN_W-bit signed PCM frames to OUT_W-bit
//   DAC words. Channels are processed one per cycle. Each channel gets
//   optional TPDF dither and error-feedback noise shaping of order 0-3.
//
// Ports
//   clk_audio  processing clock
//   rst_n      synchronous active-low reset
//   in_valid / in_ready    input frame handshake
//   in_data    packed input frame, channel c at [c*IN_W +: IN_W]
//   order      shaping order 0-3, sampled on accept
//   dither_en  TPDF dither enable, sampled on accept
//   clip_clr   clears the sticky clip flags
//   out_valid / out_ready  output frame handshake
//   out_data   packed output frame, channel c at [c*OUT_W +: OUT_W]
//   clip       sticky per-channel saturation flags
//   sat_count  saturated-sample counter, only when NS_SAT_COUNT_EN is defined
//
// Build option
//   NS_SAT_COUNT_EN  adds the sat_count port and its counter
//
// state | meaning
// IDLE  | waiting for an input frame, in_ready=1
// PROC  | processing channel ch_q, one channel per cycle
// HOLD  | output frame valid, waiting for out_ready
module noise_shaper_mc #(
  parameter int          NUM_CH    = 2,
  parameter int          IN_W      = 24,
  parameter int          OUT_W     = 16,
  parameter logic [31:0] LFSR_SEED = 32'hACE12468
) (
  input  logic                    clk_audio,
  input  logic                    rst_n,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic [NUM_CH*IN_W-1:0]  in_data,
  input  logic [1:0]              order,
  input  logic                    dither_en,
  input  logic                    clip_clr,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NUM_CH*OUT_W-1:0] out_data,
  output logic [NUM_CH-1:0]       clip
`ifdef NS_SAT_COUNT_EN
  ,
  output logic [15:0]             sat_count
`endif
);

  localparam int D  = IN_W - OUT_W;
  localparam int W  = IN_W + 4;
  localparam int CW = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic signed [W-1:0] HALF = W'(2 ** (D - 1));
  localparam logic signed [W-1:0] QMAX = W'(2 ** (OUT_W - 1) - 1);
  localparam logic signed [W-1:0] QMIN = -(W'(2 ** (OUT_W - 1)));

  // x^32+x^22+x^2+x+1, right-shifting Galois form
  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  typedef enum logic [1:0] {IDLE, PROC, HOLD} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   ch_q, ch_d;
  logic            accept, proc_en;

  logic [NUM_CH*IN_W-1:0]  frame_q;
  logic [1:0]              order_q;
  logic                    dith_q;
  logic [31:0]             lfsr_q, lfsr_next;
  logic [NUM_CH*OUT_W-1:0] out_data_q;
  logic [NUM_CH-1:0]       clip_q, clip_d;
  logic signed [W-1:0]     e1_q [NUM_CH];
  logic signed [W-1:0]     e2_q [NUM_CH];
  logic signed [W-1:0]     e3_q [NUM_CH];

  logic [IN_W-1:0]     x_raw;
  logic signed [W-1:0] x_w, e1, e2, e3, f_w, v_w, d_w, s_w, q_w, y_w, e_w;
  logic                sat_hi, sat_lo, sat;

  // ---------------- FSM ----------------
  always_ff @(posedge clk_audio) begin
    if (!rst_n) begin
      state_q <= IDLE;
      ch_q    <= '0;
    end else begin
      state_q <= state_d;
      ch_q    <= ch_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    ch_d      = ch_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    accept    = 1'b0;
    proc_en   = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) begin
          accept  = 1'b1;
          state_d = PROC;
          ch_d    = '0;
        end
      end
      PROC: begin
        proc_en = 1'b1;
        if (ch_q == CW'(NUM_CH - 1)) begin
          state_d = HOLD;
          ch_d    = '0;
        end else begin
          ch_d = ch_q + 1'b1;
        end
      end
      HOLD: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------- per-channel datapath ----------------
  always_comb begin
    x_raw = frame_q[ch_q*IN_W +: IN_W];
    x_w   = {{(W-IN_W){x_raw[IN_W-1]}}, x_raw};
    e1    = e1_q[ch_q];
    e2    = e2_q[ch_q];
    e3    = e3_q[ch_q];

    case (order_q)
      2'd0:    f_w = '0;
      2'd1:    f_w = e1;
      2'd2:    f_w = (e1 <<< 1) - e2;
      default: f_w = (e1 <<< 1) + e1 - ((e2 <<< 1) + e2) + e3;
    endcase

    v_w = x_w - f_w;

    // TPDF: difference of two independent uniform D-bit values
    d_w = '0;
    if (dith_q)
      d_w = {{(W-D){1'b0}}, lfsr_q[D-1:0]} - {{(W-D){1'b0}}, lfsr_q[D+15:16]};

    s_w    = v_w + d_w + HALF;
    q_w    = s_w >>> D;
    sat_hi = (q_w > QMAX);
    sat_lo = (q_w < QMIN);
    sat    = sat_hi | sat_lo;

    if (sat_hi)      y_w = QMAX;
    else if (sat_lo) y_w = QMIN;
    else             y_w = q_w;

    // a clamped sample would feed back a huge error, so it stores zero
    if (sat || (order_q == 2'd0)) e_w = '0;
    else                          e_w = (y_w <<< D) - v_w;
  end

  assign lfsr_next = {1'b0, lfsr_q[31:1]} ^ (lfsr_q[0] ? LFSR_TAPS : 32'h0);

  always_comb begin
    clip_d = clip_clr ? '0 : clip_q;
    if (proc_en && sat) clip_d[ch_q] = 1'b1;
  end

  always_ff @(posedge clk_audio) begin
    if (!rst_n) begin
      frame_q    <= '0;
      order_q    <= 2'd0;
      dith_q     <= 1'b0;
      lfsr_q     <= LFSR_SEED;
      out_data_q <= '0;
      clip_q     <= '0;
      for (int i = 0; i < NUM_CH; i++) begin
        e1_q[i] <= '0;
        e2_q[i] <= '0;
        e3_q[i] <= '0;
      end
    end else begin
      clip_q <= clip_d;
      if (accept) begin
        frame_q <= in_data;
        order_q <= order;
        dith_q  <= dither_en;
        // order_q still holds the previous frame's order here
        if (order != order_q) begin
          for (int i = 0; i < NUM_CH; i++) begin
            e1_q[i] <= '0;
            e2_q[i] <= '0;
            e3_q[i] <= '0;
          end
        end
      end
      if (proc_en) begin
        e3_q[ch_q] <= e2;
        e2_q[ch_q] <= e1;
        e1_q[ch_q] <= e_w;
        out_data_q[ch_q*OUT_W +: OUT_W] <= y_w[OUT_W-1:0];
        if (dith_q) lfsr_q <= lfsr_next;
      end
    end
  end

  assign out_data = out_data_q;
  assign clip     = clip_q;

`ifdef NS_SAT_COUNT_EN
  logic [15:0] sat_cnt_q, sat_cnt_d;

  always_comb begin
    sat_cnt_d = clip_clr ? 16'h0 : sat_cnt_q;
    if (proc_en && sat && (sat_cnt_d != 16'hFFFF)) sat_cnt_d = sat_cnt_d + 16'h1;
  end

  always_ff @(posedge clk_audio) begin
    if (!rst_n) sat_cnt_q <= 16'h0;
    else        sat_cnt_q <= sat_cnt_d;
  end

  assign sat_count = sat_cnt_q;
`endif

endmodule

// File: tb/tb_noise_shaper_mc.sv
module tb_noise_shaper_mc;

  localparam int NUM_CH = 2;
  localparam int IN_W   = 24;
  localparam int OUT_W  = 16;

  logic                    clk_audio = 1'b0;
  logic                    rst_n     = 1'b0;
  logic                    in_valid  = 1'b0;
  logic                    in_ready;
  logic [NUM_CH*IN_W-1:0]  in_data   = '0;
  logic [1:0]              order     = 2'd0;
  logic                    dither_en = 1'b0;
  logic                    clip_clr  = 1'b0;
  logic                    out_valid;
  logic                    out_ready = 1'b0;
  logic [NUM_CH*OUT_W-1:0] out_data;
  logic [NUM_CH-1:0]       clip;

  noise_shaper_mc #(.NUM_CH(NUM_CH), .IN_W(IN_W), .OUT_W(OUT_W),
                    .LFSR_SEED(32'hACE12468)) dut (
    .clk_audio(clk_audio), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .order(order), .dither_en(dither_en), .clip_clr(clip_clr),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .clip(clip)
  );

  always #5 clk_audio = ~clk_audio;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_audio);
    #1;
  endtask

  // ---------------- reference model ----------------
  longint      me1[NUM_CH], me2[NUM_CH], me3[NUM_CH];
  logic [31:0] mlfsr;
  int          mord;
  logic [1:0]  mclip;

  task automatic model_reset();
    for (int c = 0; c < NUM_CH; c++) begin
      me1[c] = 0; me2[c] = 0; me3[c] = 0;
    end
    mlfsr = 32'hACE12468;
    mord  = 0;
    mclip = 2'b00;
  endtask

  task automatic model_frame(input logic [23:0] x0, input logic [23:0] x1,
                             input int ord, input bit dith, output logic [31:0] y);
    longint x, f, v, d, q, yq, e;
    logic [23:0] xs;
    bit sat;
    if (ord != mord) begin
      for (int c = 0; c < NUM_CH; c++) begin
        me1[c] = 0; me2[c] = 0; me3[c] = 0;
      end
    end
    mord = ord;
    y = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      xs = (c == 0) ? x0 : x1;
      x  = $signed(xs);
      case (ord)
        0:       f = 0;
        1:       f = me1[c];
        2:       f = 2 * me1[c] - me2[c];
        default: f = 3 * me1[c] - 3 * me2[c] + me3[c];
      endcase
      v = x - f;
      d = dith ? (longint'(mlfsr[7:0]) - longint'(mlfsr[23:16])) : 0;
      q = (v + d + 128) >>> 8;
      sat = 1'b0;
      if (q > 32767)       begin yq = 32767;  sat = 1'b1; end
      else if (q < -32768) begin yq = -32768; sat = 1'b1; end
      else                 yq = q;
      e = (sat || ord == 0) ? 0 : (yq * 256 - v);
      me3[c] = me2[c]; me2[c] = me1[c]; me1[c] = e;
      if (sat) mclip[c] = 1'b1;
      y[c*16 +: 16] = yq[15:0];
      if (dith) mlfsr = {1'b0, mlfsr[31:1]} ^ (mlfsr[0] ? 32'h80200003 : 32'h0);
    end
  endtask

  // one complete frame through the DUT, with latency check
  task automatic run_frame(input logic [23:0] x0, input logic [23:0] x1,
                           input logic [1:0] ord, input bit dith, output logic [31:0] y);
    int n;
    n = 0;
    while (!in_ready && n < 20) begin tick(); n++; end
    check("in_ready_wait", in_ready, 1'b1);
    in_data   = {x1, x0};
    order     = ord;
    dither_en = dith;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    n = 0;
    while (!out_valid && n < 20) begin tick(); n++; end
    check("latency", n, 2);
    y = out_data;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    logic [31:0] y, ym;
    logic [23:0] r0, r1, x0, x1;
    logic [1:0]  ord;
    bit          dith;
    int          sum;
    logic [15:0] exp1 [8];
    logic [15:0] exp_o2 [2];
    logic [15:0] exp_o3 [3];

    exp1   = '{16'h0, 16'h1, 16'h0, 16'h0, 16'h0, 16'h1, 16'h0, 16'h0};
    exp_o2 = '{16'h0, 16'h1};
    exp_o3 = '{16'h0, 16'h1, 16'h0};

    // reset state
    rst_n = 1'b0;
    tick(); tick();
    check("rst_in_ready", in_ready, 1'b1);
    check("rst_out_valid", out_valid, 1'b0);
    check("rst_out_data", out_data, 32'h0);
    check("rst_clip", clip, 2'b00);
    rst_n = 1'b1;
    tick();

    // order 0, rounding
    run_frame(24'h123480, 24'h12347F, 2'd0, 1'b0, y);
    check("round_ch0", y[15:0], 16'h1235);
    check("round_ch1", y[31:16], 16'h1234);
    check("round_clip", clip, 2'b00);

    // saturation and clip_clr
    run_frame(24'h7FFFC0, 24'h800000, 2'd0, 1'b0, y);
    check("sat_ch0", y[15:0], 16'h7FFF);
    check("sat_ch1", y[31:16], 16'h8000);
    check("sat_clip", clip, 2'b01);
    clip_clr = 1'b1;
    tick();
    clip_clr = 1'b0;
    check("clip_clr", clip, 2'b00);

    // set wins over clip_clr: ch0 flag cleared, ch1 saturates under clear
    run_frame(24'h7FFFC0, 24'h0, 2'd0, 1'b0, y);
    check("pre_setwins_clip", clip, 2'b01);
    in_data  = {24'h7FFFC0, 24'h000000};
    in_valid = 1'b1;
    clip_clr = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("setwins_valid", out_valid, 1'b1);
    check("setwins_clip", clip, 2'b10);
    check("setwins_ch1", out_data[31:16], 16'h7FFF);
    clip_clr  = 1'b0;
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;

    // order 1 from reset, constant 0x40: 0,1,0,0 repeating, mean 1/4 LSB
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    sum = 0;
    for (int i = 0; i < 8; i++) begin
      run_frame(24'h000040, 24'h0, 2'd1, 1'b0, y);
      check($sformatf("o1_ch0_f%0d", i), y[15:0], exp1[i]);
      check($sformatf("o1_ch1_f%0d", i), y[31:16], 16'h0);
      sum += int'(y[15:0]);
    end
    check("o1_mean_sum", sum, 2);

    // switch to order 2: history cleared
    for (int i = 0; i < 2; i++) begin
      run_frame(24'h000040, 24'h0, 2'd2, 1'b0, y);
      check($sformatf("o2_ch0_f%0d", i), y[15:0], exp_o2[i]);
    end

    // order 3
    for (int i = 0; i < 3; i++) begin
      run_frame(24'h000040, 24'h0, 2'd3, 1'b0, y);
      check($sformatf("o3_ch0_f%0d", i), y[15:0], exp_o3[i]);
    end

    // backpressure in HOLD
    in_data   = {24'h12347F, 24'h123480};
    order     = 2'd0;
    dither_en = 1'b0;
    in_valid  = 1'b1;
    tick();
    in_valid = 1'b0;
    tick(); tick();
    check("bp_valid0", out_valid, 1'b1);
    for (int i = 0; i < 10; i++) begin
      tick();
      check($sformatf("bp_valid_%0d", i), out_valid, 1'b1);
      check($sformatf("bp_data_%0d", i), out_data, 32'h1234_1235);
      check($sformatf("bp_ready_%0d", i), in_ready, 1'b0);
    end
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    check("bp_release_valid", out_valid, 1'b0);
    check("bp_release_ready", in_ready, 1'b1);

    // reset during PROC
    in_data  = {24'h400000, 24'h300000};
    in_valid = 1'b1;
    tick();
    in_valid = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    check("midrst_in_ready", in_ready, 1'b1);
    check("midrst_out_valid", out_valid, 1'b0);
    check("midrst_out_data", out_data, 32'h0);
    check("midrst_clip", clip, 2'b00);
    model_reset();

    // first frame after reset is dithered: exposes the LFSR seed
    run_frame(24'h001234, 24'hFFEDCB, 2'd1, 1'b1, y);
    model_frame(24'h001234, 24'hFFEDCB, 1, 1'b1, ym);
    check("seed_frame", y, ym);

    // dither off: LFSR must hold across these frames
    for (int i = 0; i < 5; i++) begin
      run_frame(24'h000100 * i, 24'h000055, 2'd0, 1'b0, y);
      model_frame(24'h000100 * i, 24'h000055, 0, 1'b0, ym);
      check($sformatf("nodith_f%0d", i), y, ym);
    end

    // 1000 frames against the model
    for (int i = 0; i < 1000; i++) begin
      r0 = 24'($urandom);
      r1 = 24'($urandom);
      if (i % 50 == 0) begin
        x0 = r0;
        x1 = r1;
      end else begin
        x0 = {{2{r0[23]}}, r0[23:2]};
        x1 = {{2{r1[23]}}, r1[23:2]};
      end
      ord  = 2'((i / 125) % 4);
      dith = (i % 7 != 3);
      run_frame(x0, x1, ord, dith, y);
      model_frame(x0, x1, int'(ord), dith, ym);
      check($sformatf("model_f%0d", i), y, ym);
      check($sformatf("model_clip_f%0d", i), clip, mclip);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/noise_shaper_mc.md
Name: noise_shaper_mc

Overview:
Parametrised multichannel requantiser. It takes wide PCM frames from the DSP pipeline and reduces them to the DAC word width. Each channel gets optional TPDF dither and error-feedback noise shaping of order 0-3. Channels are processed time-multiplexed, one per cycle, with frame-level valid/ready handshakes on both sides.

Parameters:
- NUM_CH, 2, channel count (1-16).
- IN_W, 24, input sample width, signed.
- OUT_W, 16, output sample width, signed. D = IN_W-OUT_W is required to satisfy 1<=D<=16.
- LFSR_SEED, 32'hACE12468, dither LFSR reset value; must be nonzero.

Ports:
- clk_audio  in  1  processing clock
- rst_n  in  1  reset; synchronous, active-low; clock clk_audio
- in_valid  in  1  input frame valid
- in_ready  out  1  block can accept a frame
- in_data  in  NUM_CH*IN_W  packed frame; channel c at [c*IN_W +: IN_W]
- order  in  2  shaping order 0-3; sampled on accept
- dither_en  in  1  TPDF dither enable; sampled on accept
- clip_clr  in  1  clears clip flags
- out_valid  out  1  output frame valid
- out_ready  in  1  downstream accepts the frame
- out_data  out  NUM_CH*OUT_W  packed output, same channel layout as in_data
- clip  out  NUM_CH  sticky per-channel saturation flags

Behaviour:
- Reset (rst_n=0 at a clk_audio edge):
  - State goes to IDLE. in_ready=1, out_valid=0, out_data=0, clip=0.
  - All error states are cleared to 0. LFSR loads LFSR_SEED.
  - Reset applies in any state, including mid-PROC or HOLD. Any partial frame is discarded.
- FSM states: IDLE, PROC, HOLD.
- IDLE:
  - in_ready=1.
  - On in_valid at edge k: latch the frame, order and dither_en; go to PROC with ch=0.
- PROC:
  - in_ready=0.
  - Edges k+1 .. k+NUM_CH each process channel ch, then ch increments.
  - The edge that processes ch=NUM_CH-1 sets out_valid=1 and goes to HOLD.
  - Latency is NUM_CH cycles from accept to out_valid.
- HOLD:
  - out_valid=1 and out_data are held stable.
  - out_valid & out_ready at an edge: out_valid=0, go to IDLE. in_ready=1 in the following cycle.
  - Maximum throughput is one frame per NUM_CH+2 cycles.
- Per-channel datapath: internal width W = IN_W+4, signed.
  - e1, e2, e3 are the previous three quantisation errors of the channel.
  - Error feedback f by order:
    - order 0: f=0
    - order 1: f=e1
    - order 2: f=2e1-e2
    - order 3: f=3e1-3e2+e3
  - v = x - f.
  - Dither: r1 = lfsr[D-1:0] and r2 = lfsr[D+15:16], both unsigned. d = r1-r2 when dither enabled, else d=0.
  - Quantise: q = (v + d + 2^(D-1)) >>> D, arithmetic shift.
  - Saturate: y = q clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
  - Error: e = (y<<D) - v. Shift history: e3<=e2, e2<=e1, e1<=e.
  - Saturation handling: if q was clamped, set clip[ch] and store e=0 rather than the computed error (prevents runaway feedback).
  - Noise transfer function is (1-z^-1)^order.
  - For order 0, stored errors are forced to 0.
- Order change: if the latched order differs from the previous frame's order, all channels' e1-e3 are cleared before that frame is processed.
- LFSR:
  - 32-bit Galois, polynomial x^32+x^22+x^2+x+1.
  - Advances once per processed channel when dither is enabled; holds otherwise.
- clip_clr: clears all clip bits. If a saturation occurs on the same edge, that bit is set (set wins).

Optional Feature:
- Macro: NS_SAT_COUNT_EN.
- Defined:
  - Adds output port sat_count, 16 bits.
  - Counts saturated samples across all channels; saturates at 16'hFFFF.
  - Cleared by reset and by clip_clr. A same-edge saturation makes the value 1.
- Undefined: no port and no counter logic; behaviour is otherwise identical.

Test Plan:
- Defaults, order 0, dither off:
  - ch0=24'h123480 -> 16'h1235; ch1=24'h12347F -> 16'h1234.
  - out_valid rises exactly 2 cycles after accept.
- Saturation:
  - ch0=24'h7FFFC0 -> 16'h7FFF, clip[0]=1.
  - ch1=24'h800000 -> 16'h8000, clip[1]=0.
  - clip_clr pulse -> clip=0.
- Order 1, dither off, constant input 24'h000040 on ch0:
  - Output repeats 0,1,0,0 from the first frame after reset.
  - Mean is exactly 0.25 LSB.
- Backpressure: hold out_ready=0 for 10 cycles in HOLD:
  - out_valid/out_data stay stable and in_ready=0.
  - One-cycle out_ready -> in_ready=1 on the next cycle.
- Order switch 1->2 mid-stream with input 0x40: the first order-2 frame outputs 0 (errors were cleared).
- rst_n=0 during PROC:
  - Next cycle in_ready=1, out_valid=0, out_data=0, LFSR=LFSR_SEED.
  - With dither on, output matches the reference model bit-exactly over 1000 frames.
  - With dither_en=0, the LFSR does not advance.
